// File: rtl/switch_pkg.sv
// Shared types and helper functions for the N-port address-routed switch.
package switch_pkg;

   // Widest address the broadcast helper can describe.
   localparam int MAX_ADDR_W = 32;

   // Route decode for an incoming word: one port, or every port.
   typedef enum logic [0:0] {
      ROUTE_UNI   = 1'b0,
      ROUTE_BCAST = 1'b1
   } route_t;

   // Number of address MSBs needed to select one of n ports.
   function automatic int port_sel_w(input int n);
      return $clog2(n);
   endfunction

   // All-ones value of the given width (the reserved broadcast address).
   function automatic logic [MAX_ADDR_W-1:0] bcast_addr(input int width);
      logic [MAX_ADDR_W-1:0] v;
      v = {MAX_ADDR_W{1'b0}};
      for (int i = 0; i < MAX_ADDR_W; i++) begin
         if (i < width) begin
            v[i] = 1'b1;
         end else begin
            v[i] = 1'b0;
         end
      end
      return v;
   endfunction

endpackage

// File: rtl/switch_if.sv
// Input stream plus packed per-port output channels of the N-port switch.
interface switch_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PORTS  = 4
);
   logic                            vld;
   logic                            rdy;
   logic [ADDR_WIDTH-1:0]           addr;
   logic [DATA_WIDTH-1:0]           data;
   logic [NUM_PORTS-1:0]            out_vld;
   logic [NUM_PORTS-1:0]            out_rdy;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
   logic [NUM_PORTS-1:0]            port_full;

   // Source/sink side: drives the input word and the downstream readies.
   modport master (
      output vld, addr, data, out_rdy,
      input  rdy, out_vld, out_addr, out_data, port_full
   );

   // Switch side.
   modport slave (
      input  vld, addr, data, out_rdy,
      output rdy, out_vld, out_addr, out_data, port_full
   );
endinterface

// File: rtl/switch_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and registered flags.
// A push into a full FIFO is dropped even if a pop happens the same cycle;
// the switch never offers such a push because rdy already excludes it.
module switch_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr_r;
   logic [PW:0]      rd_ptr_r;
   logic [PW:0]      wr_nxt_s;
   logic [PW:0]      rd_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic             do_push_s;
   logic             do_pop_s;

   // Qualify requests against the current flags and compute next pointers.
   always_comb begin
      do_push_s = push && !full_r;
      do_pop_s  = pop && !empty_r;
      if (do_push_s) begin
         wr_nxt_s = wr_ptr_r + {{PW{1'b0}}, 1'b1};
      end else begin
         wr_nxt_s = wr_ptr_r;
      end
      if (do_pop_s) begin
         rd_nxt_s = rd_ptr_r + {{PW{1'b0}}, 1'b1};
      end else begin
         rd_nxt_s = rd_ptr_r;
      end
   end

   // Pointer and flag registers; flags are derived from the next pointers so they stay registered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {(PW+1){1'b0}};
         rd_ptr_r <= {(PW+1){1'b0}};
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         wr_ptr_r <= wr_nxt_s;
         rd_ptr_r <= rd_nxt_s;
         full_r   <= (wr_nxt_s[PW-1:0] == rd_nxt_s[PW-1:0]) && (wr_nxt_s[PW] != rd_nxt_s[PW]);
         empty_r  <= (wr_nxt_s == rd_nxt_s);
      end
   end

   // Storage array; contents need no reset because the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem[wr_ptr_r[PW-1:0]] <= din;
      end
   end

   // Head is forced to zero while empty so nothing stale is ever presented.
   always_comb begin
      if (empty_r) begin
         head = {WIDTH{1'b0}};
      end else begin
         head = mem[rd_ptr_r[PW-1:0]];
      end
   end

   assign full  = full_r;
   assign empty = empty_r;

endmodule

// File: rtl/switch_nport.sv
// N-output address-routed switch: one input stream steered by the address
// MSBs to per-port FWFT FIFOs; an all-ones address optionally broadcasts.
// rdy depends only on addr and the registered full flags, never on out_rdy.
module switch_nport
   import switch_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int NUM_PORTS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter bit BCAST_EN   = 1'b1
) (
   input logic     clk,
   input logic     rst,
   switch_if.slave bus
);
   localparam int PSW = port_sel_w(NUM_PORTS);
   localparam int FW  = ADDR_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] BCAST = ADDR_WIDTH'(bcast_addr(ADDR_WIDTH));

   route_t               route_s;
   logic [PSW-1:0]       sel_s;
   logic                 rdy_s;
   logic                 accept_s;
   logic [NUM_PORTS-1:0] push_s;
   logic [NUM_PORTS-1:0] pop_s;
   logic [NUM_PORTS-1:0] full_s;
   logic [NUM_PORTS-1:0] empty_s;
   logic [FW-1:0]        head_s [NUM_PORTS];

   // Decode destination port and route type from the input address.
   always_comb begin
      sel_s = bus.addr[ADDR_WIDTH-1 -: PSW];
      if (BCAST_EN && (bus.addr == BCAST)) begin
         route_s = ROUTE_BCAST;
      end else begin
         route_s = ROUTE_UNI;
      end
   end

   // Accept only if every targeted FIFO has room, which keeps broadcast atomic.
   always_comb begin
      case (route_s)
         ROUTE_UNI:   rdy_s = !full_s[sel_s];
         ROUTE_BCAST: rdy_s = !(|full_s);
         default:     rdy_s = 1'b0;
      endcase
      accept_s = bus.vld && rdy_s;
   end

   // Per-port push enables for an accepted word.
   always_comb begin
      push_s = {NUM_PORTS{1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
         case (route_s)
            ROUTE_UNI:   push_s[p] = accept_s && (sel_s == PSW'(p));
            ROUTE_BCAST: push_s[p] = accept_s;
            default:     push_s[p] = 1'b0;
         endcase
      end
   end

   assign pop_s = ~empty_s & bus.out_rdy;

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      switch_fifo #(
         .WIDTH (FW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_s[g]),
         .pop   (pop_s[g]),
         .din   ({bus.addr, bus.data}),
         .full  (full_s[g]),
         .empty (empty_s[g]),
         .head  (head_s[g])
      );
   end

   // Pack each FIFO head onto the flat per-port output buses.
   always_comb begin
      bus.out_addr = {(NUM_PORTS*ADDR_WIDTH){1'b0}};
      bus.out_data = {(NUM_PORTS*DATA_WIDTH){1'b0}};
      for (int p = 0; p < NUM_PORTS; p++) begin
         bus.out_addr[p*ADDR_WIDTH +: ADDR_WIDTH] = head_s[p][DATA_WIDTH +: ADDR_WIDTH];
         bus.out_data[p*DATA_WIDTH +: DATA_WIDTH] = head_s[p][DATA_WIDTH-1:0];
      end
   end

   assign bus.rdy       = rdy_s;
   assign bus.out_vld   = ~empty_s;
   assign bus.port_full = full_s;

endmodule

// File: tb/tb_switch_nport.sv
// Directed bench for switch_nport: fan-out, backpressure, isolation,
// broadcast (enabled and disabled), pointer wrap and mid-stream reset.
module tb_switch_nport;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   sent;
   int   rcv;
   logic acc;
   logic pop;

   logic [7:0]  fa [4];
   logic [15:0] fd [4];

   switch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_PORTS(4)) bus  ();
   switch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_PORTS(4)) bus2 ();

   switch_nport #(
      .ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_PORTS(4), .FIFO_DEPTH(4), .BCAST_EN(1'b1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   switch_nport #(
      .ADDR_WIDTH(8), .DATA_WIDTH(16), .NUM_PORTS(4), .FIFO_DEPTH(4), .BCAST_EN(1'b0)
   ) dut_nb (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] oa(input int p);
      return bus.out_addr[p*8 +: 8];
   endfunction

   function automatic logic [15:0] od(input int p);
      return bus.out_data[p*16 +: 16];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      fa = '{8'h05, 8'h45, 8'h85, 8'hC5};
      fd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      rst = 1'b1;
      bus.vld = 1'b0;  bus.addr = 8'h00;  bus.data = 16'h0000;  bus.out_rdy = 4'hF;
      bus2.vld = 1'b0; bus2.addr = 8'h00; bus2.data = 16'h0000; bus2.out_rdy = 4'hF;

      // ---- reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_vld", 32'(bus.out_vld), 32'h0);
      chk("rst_port_full", 32'(bus.port_full), 32'h0);
      chk("rst_out_addr", 32'(bus.out_addr), 32'h0);
      chk("rst_out_data", 32'(bus.out_data[31:0]), 32'h0);
      chk("rst_rdy_uni", 32'(bus.rdy), 32'h1);
      bus.addr = 8'hFF;
      #1;
      chk("rst_rdy_bcast", 32'(bus.rdy), 32'h1);
      bus.addr = 8'h00;
      @(negedge clk);
      rst = 1'b0;

      // ---- unicast fan-out, back to back
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.vld = 1'b1; bus.addr = fa[i]; bus.data = fd[i];
         #1;
         chk("fan_rdy", 32'(bus.rdy), 32'h1);
         @(posedge clk);
         #1;
         chk("fan_out_vld", 32'(bus.out_vld), 32'(1 << i));
         chk("fan_out_addr", 32'(oa(i)), 32'(fa[i]));
         chk("fan_out_data", 32'(od(i)), 32'(fd[i]));
      end
      @(negedge clk);
      bus.vld = 1'b0;
      @(posedge clk);
      #1;
      chk("fan_drained", 32'(bus.out_vld), 32'h0);

      // ---- backpressure on port 2: fill it
      @(negedge clk);
      bus.out_rdy = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         bus.vld = 1'b1; bus.addr = 8'h80 + 8'(i); bus.data = 16'h5000 + 16'(i);
         #1;
         chk("bp_rdy", 32'(bus.rdy), 32'h1);
         @(posedge clk);
         #1;
      end
      chk("bp_port_full", 32'(bus.port_full), 32'h4);
      chk("bp_out_vld", 32'(bus.out_vld), 32'h4);

      // ---- head-of-line isolation: port 0 still accepts
      @(negedge clk);
      bus.addr = 8'h10; bus.data = 16'h1010;
      #1;
      chk("hol_rdy", 32'(bus.rdy), 32'h1);
      @(posedge clk);
      #1;
      chk("hol_out_vld", 32'(bus.out_vld), 32'h5);
      chk("hol_addr", 32'(oa(0)), 32'h10);
      chk("hol_data", 32'(od(0)), 32'h1010);

      // ---- fifth word to full port 2 is held
      @(negedge clk);
      bus.addr = 8'h84; bus.data = 16'h5004;
      #1;
      chk("bp5_rdy_low", 32'(bus.rdy), 32'h0);
      @(posedge clk);
      #1;
      chk("bp5_out_vld", 32'(bus.out_vld), 32'h4);
      chk("bp5_head", 32'(oa(2)), 32'h80);
      chk("bp5_full", 32'(bus.port_full), 32'h4);
      @(negedge clk);
      bus.out_rdy = 4'hF;
      #1;
      chk("bp_no_comb_path", 32'(bus.rdy), 32'h0);
      @(posedge clk);
      #1;
      chk("bp_drain_addr1", 32'(oa(2)), 32'h81);
      chk("bp_drain_data1", 32'(od(2)), 32'h5001);
      chk("bp_full_clear", 32'(bus.port_full), 32'h0);
      chk("bp5_rdy_high", 32'(bus.rdy), 32'h1);
      for (int i = 2; i < 5; i++) begin
         @(posedge clk);
         #1;
         bus.vld = 1'b0;
         chk("bp_drain_addr", 32'(oa(2)), 32'(8'h80 + 8'(i)));
         chk("bp_drain_data", 32'(od(2)), 32'(16'h5000 + 16'(i)));
      end
      @(posedge clk);
      #1;
      chk("bp_drained", 32'(bus.out_vld), 32'h0);

      // ---- broadcast
      @(negedge clk);
      bus.vld = 1'b1; bus.addr = 8'hFF; bus.data = 16'hABCD;
      #1;
      chk("bc_rdy", 32'(bus.rdy), 32'h1);
      @(posedge clk);
      #1;
      bus.vld = 1'b0;
      chk("bc_out_vld", 32'(bus.out_vld), 32'hF);
      for (int p = 0; p < 4; p++) begin
         chk("bc_addr", 32'(oa(p)), 32'hFF);
         chk("bc_data", 32'(od(p)), 32'hABCD);
      end
      @(posedge clk);
      #1;
      chk("bc_drained", 32'(bus.out_vld), 32'h0);

      // ---- broadcast blocked by full port 1
      @(negedge clk);
      bus.out_rdy = 4'b1101;
      for (int i = 0; i < 4; i++) begin
         if (i > 0) @(negedge clk);
         bus.vld = 1'b1; bus.addr = 8'h40 + 8'(i); bus.data = 16'h4100 + 16'(i);
         #1;
         chk("bcf_fill_rdy", 32'(bus.rdy), 32'h1);
         @(posedge clk);
         #1;
      end
      chk("bcf_port_full", 32'(bus.port_full), 32'h2);
      @(negedge clk);
      bus.addr = 8'hFF; bus.data = 16'hBEEF;
      #1;
      chk("bcf_rdy_low", 32'(bus.rdy), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("bcf_no_partial", 32'(bus.out_vld), 32'h2);
      chk("bcf_head1", 32'(oa(1)), 32'h40);
      @(negedge clk);
      bus.out_rdy = 4'hF;
      @(posedge clk);
      #1;
      chk("bcf_rdy_high", 32'(bus.rdy), 32'h1);
      @(posedge clk);
      #1;
      bus.vld = 1'b0;
      chk("bcf_out_vld", 32'(bus.out_vld), 32'hF);
      chk("bcf_addr0", 32'(oa(0)), 32'hFF);
      chk("bcf_data0", 32'(od(0)), 32'hBEEF);
      chk("bcf_addr3", 32'(oa(3)), 32'hFF);
      chk("bcf_head1_next", 32'(oa(1)), 32'h42);
      repeat (2) @(posedge clk);
      #1;
      chk("bcf_tail_vld", 32'(bus.out_vld), 32'h2);
      chk("bcf_tail_addr", 32'(oa(1)), 32'hFF);
      chk("bcf_tail_data", 32'(od(1)), 32'hBEEF);
      @(posedge clk);
      #1;
      chk("bcf_drained", 32'(bus.out_vld), 32'h0);

      // ---- broadcast disabled: 0xFF is plain port 3 traffic
      @(negedge clk);
      bus2.vld = 1'b1; bus2.addr = 8'hFF; bus2.data = 16'h7777;
      #1;
      chk("nb_rdy", 32'(bus2.rdy), 32'h1);
      @(posedge clk);
      #1;
      bus2.vld = 1'b0;
      chk("nb_out_vld", 32'(bus2.out_vld), 32'h8);
      chk("nb_addr", 32'(bus2.out_addr[31:24]), 32'hFF);
      chk("nb_data", 32'(bus2.out_data[63:48]), 32'h7777);
      @(posedge clk);
      #1;
      chk("nb_drained", 32'(bus2.out_vld), 32'h0);

      // ---- wrap-around: 20 words to port 0 with toggling out_rdy[0]
      sent = 0;
      rcv  = 0;
      for (int cyc = 0; cyc < 200 && rcv < 20; cyc++) begin
         @(negedge clk);
         bus.out_rdy = {3'b111, ~cyc[0]};
         bus.vld  = (sent < 20);
         bus.addr = 8'(sent);
         bus.data = 16'h6000 + 16'(sent);
         #1;
         acc = bus.vld && bus.rdy;
         pop = bus.out_vld[0] && bus.out_rdy[0];
         if (pop) begin
            chk("wrap_addr", 32'(oa(0)), 32'(rcv));
            chk("wrap_data", 32'(od(0)), 32'(16'h6000 + 16'(rcv)));
            rcv++;
         end
         @(posedge clk);
         if (acc) sent++;
      end
      bus.vld = 1'b0;
      #1;
      chk("wrap_sent", 32'(sent), 32'd20);
      chk("wrap_rcvd", 32'(rcv), 32'd20);
      @(posedge clk);
      #1;
      chk("wrap_drained", 32'(bus.out_vld), 32'h0);

      // ---- reset mid-stream with 3 words on port 1
      @(negedge clk);
      bus.out_rdy = 4'b1101;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         bus.vld = 1'b1; bus.addr = 8'h40 + 8'(i); bus.data = 16'h9000 + 16'(i);
         @(posedge clk);
         #1;
      end
      bus.vld = 1'b0;
      chk("mr_buffered", 32'(bus.out_vld), 32'h2);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("mr_async_vld", 32'(bus.out_vld), 32'h0);
      chk("mr_async_full", 32'(bus.port_full), 32'h0);
      chk("mr_async_addr", 32'(bus.out_addr), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      bus.out_rdy = 4'hF;
      bus.addr = 8'h40;
      #1;
      chk("mr_rdy", 32'(bus.rdy), 32'h1);
      chk("mr_port_full", 32'(bus.port_full), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("mr_no_stale", 32'(bus.out_vld), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/switch_nport.md
# switch_nport

Parametrised N-output address-routed packet switch with per-port buffering. It is the next generation of the two-output (a/b) switch. A single input stream of {addr, data} words with a valid/ready handshake is steered by address to one of NUM_PORTS output channels. A reserved broadcast address copies the word to every channel. Each output channel has its own FIFO and its own valid/ready handshake, so a stalled port does not block traffic to the other ports.

## Interface
- ADDR_WIDTH, 8: address width; must be greater than PORT_SEL_W.
- DATA_WIDTH, 16: payload width.
- NUM_PORTS, 4: output channel count; power of two, 2..16.
- FIFO_DEPTH, 4: entries per output FIFO; power of two, at least 2.
- BCAST_EN, 1: 1 makes address all-ones a broadcast; 0 routes it as a normal address.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- vld  in  1  input word valid.
- rdy  out  1  switch can accept the input word this cycle.
- addr  in  ADDR_WIDTH  input destination address.
- data  in  DATA_WIDTH  input payload.
- out_vld  out  NUM_PORTS  per-port output valid.
- out_rdy  in  NUM_PORTS  per-port downstream ready.
- out_addr  out  NUM_PORTS*ADDR_WIDTH  per-port address; port p occupies [p*ADDR_WIDTH +: ADDR_WIDTH].
- out_data  out  NUM_PORTS*DATA_WIDTH  per-port payload, packed the same way.
- port_full  out  NUM_PORTS  per-port FIFO-full status, registered.

## Operation
- Port select is addr[ADDR_WIDTH-1 -: PORT_SEL_W], where PORT_SEL_W = log2(NUM_PORTS). With the defaults this is addr[7:6], so 0x00–0x3F go to port 0 and 0xC0–0xFF go to port 3.
- Broadcast: when BCAST_EN=1 and addr is all-ones, the target is every port.
- rdy is combinational from addr, vld-independent, and the registered FIFO full flags:
  - unicast: rdy = !full[sel];
  - broadcast: rdy = no FIFO full.
- rdy never depends on out_rdy, so there is no comb path from out_rdy to rdy.
- Transfer occurs when vld && rdy at a rising edge. The word is pushed into the selected FIFO, or into all FIFOs for broadcast.
- Broadcast is atomic: it is either written to all ports in the same cycle or to none.
- vld without rdy: nothing is written. The source must hold vld, addr and data stable until rdy.
- Output FIFOs are first-word-fall-through:
  - out_vld[p] = !empty[p];
  - out_addr/out_data show the head entry;
  - a pop occurs when out_vld[p] && out_rdy[p].
- A full FIFO rejects a push even if a pop happens in the same cycle. This is a conservative rule.
- Pushes and pops on a non-full, non-empty FIFO in the same cycle both happen; occupancy is unchanged.
- Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit:
  - full when the low bits are equal and the wrap bits differ;
  - empty when the pointers are equal.
- Words reach each port in arrival order. There is no ordering guarantee between ports.

## Timing
- Reset (async assert, sync release by the system):
  - all FIFOs empty;
  - out_vld = 0, port_full = 0;
  - rdy = 1 for every addr.
- out_addr and out_data are 0 after reset. When out_vld is 0 they are don't-care.
- Latency: a word accepted at edge N shows out_vld=1 after edge N, i.e. it is visible in cycle N+1, provided its FIFO was empty.
- Throughput: one input word per cycle. Each port can drain one word per cycle.
- port_full updates the cycle after the push that fills the FIFO.
- Reset asserted mid-stream: all buffered words are discarded immediately and outputs go to their reset values asynchronously.

## Structure
- Package switch_pkg holds:
  - the function port_sel_w(n) = $clog2(n);
  - the function bcast_addr(width), returning all-ones;
  - the unicast/broadcast decode enum (ROUTE_UNI, ROUTE_BCAST).
- Sub-module switch_fifo: parametrised FWFT FIFO (width, depth) with push, pop, full, empty and head outputs.
- switch_nport instantiates NUM_PORTS copies of switch_fifo in a generate loop and contains the route decode and rdy logic.
- The bench-side interface is a parametrised successor of switch_if, with packed output arrays.

## Test plan
Defaults apply unless stated.
- Unicast fan-out: send 0x05/0x1111, 0x45/0x2222, 0x85/0x3333, 0xC5/0x4444 with all out_rdy=1 → each port shows exactly one word, the next cycle after acceptance, with matching addr and data.
- Backpressure: out_rdy[2]=0, send 5 words to 0x80 → first 4 accepted; rdy=0 on the 5th; port_full[2]=1. Then raise out_rdy[2] → words 0x80.. drain in order and the 5th is accepted afterwards.
- Head-of-line isolation: with port 2 full, send 0x10 → accepted immediately and appears on port 0.
- Broadcast: send 0xFF/0xABCD → all 4 out_vld rise in the same cycle with 0xFF/0xABCD. With port 1 full, broadcast is held (rdy=0) and no port receives a partial copy. With BCAST_EN=0, 0xFF goes to port 3 only.
- Wrap-around: stream 20 words to port 0 at full rate with out_rdy[0] toggling 1/0 → all 20 arrive in order and none are lost or duplicated.
- Reset mid-operation: assert rst with 3 words buffered on port 1 → out_vld=0 immediately; after release, port_full=0, rdy=1, and no stale data appears.
